// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default operand width.
package seq_divider_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, conditionally subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic [WIDTH-1:0] quo_c_o
);

  logic [WIDTH:0] shifted_c;
  logic [WIDTH:0] diff_c;

  // Shifted remainder needs one extra bit because it can exceed WIDTH bits before the subtract.
  always_comb begin
    shifted_c = {rem_i, quo_i[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, dvs_i};
    if (shifted_c >= {1'b0, dvs_i}) begin
      rem_c_o = diff_c[WIDTH-1:0];
      quo_c_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_c_o = shifted_c[WIDTH-1:0];
      quo_c_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider: one restoring step per cycle, sign fix-up at the end.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;

  logic [WIDTH-1:0] dvd_abs_c;
  logic [WIDTH-1:0] dvs_abs_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH-1:0] quo_nxt_c;

  always_comb begin
    dvd_abs_c = (is_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    dvs_abs_c = (is_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .dvs_i   (dvs_q),
    .rem_c_o (rem_nxt_c),
    .quo_c_o (quo_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q       <= '0;
            quo_q       <= dvd_abs_c;
            dvs_q       <= dvs_abs_c;
            dvd_q       <= dividend;
            neg_quo_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q   <= is_signed & dividend[WIDTH-1];
            zero_q      <= (divisor == '0);
            count_q     <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state_q     <= (divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          rem_q   <= rem_nxt_c;
          quo_q   <= quo_nxt_c;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // A zero divisor skips RUN, so it settles in FIX for one extra cycle before results post.
          if (zero_q && (count_q == '0)) begin
            count_q <= CNT_W'(1);
          end else begin
            if (zero_q) begin
              quotient  <= '1;
              remainder <= dvd_q;
            end else begin
              quotient  <= neg_quo_q ? WIDTH'(-quo_q) : quo_q;
              remainder <= neg_rem_q ? WIDTH'(-rem_q) : rem_q;
            end
            div_by_zero <= zero_q;
            done        <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed quotients, remainders and latencies.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_err;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one division from IDLE and returns edges-to-done plus status right after the start edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_n, output logic dbz_n);
    repeat (2) @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    busy_n = busy;
    dbz_n  = div_by_zero;
    lat    = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int   lat;
  logic b_n;
  logic z_n;
  int   seen;

  initial begin
    n_checks  = 0;
    n_err     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, lat, b_n, z_n);
    check("u100_7_busy", 32'(b_n), 32'd1);
    check("u100_7_lat", 32'(lat), 32'd33);
    check("u100_7_quo", quotient, 32'd14);
    check("u100_7_rem", remainder, 32'd2);
    check("u100_7_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    check("u100_7_pulse", 32'(done), 32'd0);
    check("u100_7_idle", 32'(busy), 32'd0);
    check("u100_7_hold", quotient, 32'd14);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, b_n, z_n);
    check("sm7_2_lat", 32'(lat), 32'd33);
    check("sm7_2_quo", quotient, 32'hFFFF_FFFD);
    check("sm7_2_rem", remainder, 32'hFFFF_FFFF);

    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, b_n, z_n);
    check("u_min_m1_quo", quotient, 32'd0);
    check("u_min_m1_rem", remainder, 32'h8000_0000);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b_n, z_n);
    check("s_min_m1_quo", quotient, 32'h8000_0000);
    check("s_min_m1_rem", remainder, 32'd0);
    check("s_min_m1_dbz", 32'(div_by_zero), 32'd0);

    run_op(1'b0, 32'd5, 32'd0, lat, b_n, z_n);
    check("dz_lat", 32'(lat), 32'd2);
    check("dz_quo", quotient, 32'hFFFF_FFFF);
    check("dz_rem", remainder, 32'd5);
    check("dz_dbz", 32'(div_by_zero), 32'd1);
    @(posedge clk);
    #1;
    check("dz_hold", 32'(div_by_zero), 32'd1);

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, b_n, z_n);
    check("dz_clear", 32'(z_n), 32'd0);
    check("s7_m2_quo", quotient, 32'hFFFF_FFFD);
    check("s7_m2_rem", remainder, 32'd1);

    run_op(1'b0, 32'h1234_5678, 32'h10, lat, b_n, z_n);
    check("u_hex_quo", quotient, 32'h0123_4567);
    check("u_hex_rem", remainder, 32'd8);

    // Start re-pulsed mid-RUN with other operands must not disturb the running division.
    repeat (2) @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 7; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("ign_lat", 32'(lat), 32'd33);
    check("ign_quo", quotient, 32'd14);
    check("ign_rem", remainder, 32'd2);

    // Reset after RUN step 10 aborts the operation and clears every output.
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd200;
    divisor  = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quo", quotient, 32'd0);
    check("abort_rem", remainder, 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("rst_prio_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); latched with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; latched with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; latched with start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port quotient  output  WIDTH  result, held until the next accepted start.
REQ-011 SHALL have port remainder  output  WIDTH  result, held until the next accepted start.
REQ-012 SHALL have port div_by_zero  output  1  set with done when divisor was 0; held with results.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL, on IDLE with start=1 at edge N: latch operand magnitudes (absolute value when is_signed and negative), result signs, and count=0; go to RUN, or to FIX if divisor==0.
REQ-015 SHALL, in RUN, perform one restoring step per cycle: shift {rem,quo} left 1; if rem >= divisor magnitude, subtract it and set quo LSB=1.
REQ-016 SHALL leave RUN for FIX after exactly WIDTH steps (edges N+1..N+WIDTH).
REQ-017 SHALL, in FIX (one cycle): negate quotient if operand signs differ and remainder if dividend was negative (signed mode only); register quotient, remainder, div_by_zero; go to DONE.
REQ-018 SHALL assert done for exactly the DONE cycle (after edge N+WIDTH+1, i.e. N+33 at default), then return to IDLE.
REQ-019 SHALL ignore start in RUN, FIX and DONE; no queuing.
REQ-020 SHALL, for divisor==0, produce quotient = all ones, remainder = original dividend, div_by_zero=1, done after edge N+2.
REQ-021 SHALL, for signed most-negative / -1, produce quotient = most-negative value, remainder=0, div_by_zero=0 (no trap).
REQ-022 SHALL give remainder the sign of the dividend; |remainder| < |divisor|.
REQ-023 SHALL clear div_by_zero on every accepted start.

Reset
REQ-024 SHALL, with reset=1 at any edge including mid-operation: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
REQ-025 SHALL give reset priority over start in the same cycle.

Structure
REQ-026 SHALL place the state enum and WIDTH default constant in the shared processor package.
REQ-027 SHALL isolate the combinational compare-and-subtract step in one sub-module, div_step.
REQ-028 SHALL keep the iteration counter at clog2(WIDTH)+1 bits.

Verification
REQ-029 SHALL cover unsigned 100/7, start at edge N -> done after N+33, quotient=14, remainder=2, div_by_zero=0.
REQ-030 SHALL cover signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0x80000000/0xFFFFFFFF -> quotient=0, remainder=0x80000000.
REQ-031 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-032 SHALL cover 5/0 -> done after N+2, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-033 SHALL cover start pulsed during RUN (ignored, results unchanged), then reset at RUN step 10 -> next cycle busy=0, done=0, outputs 0, no done pulse later.
